bounce_counter_p: RTL and testbench
===================================

# bounce_counter_p

Parametrised up/down/bounce counter: the next generation of the 4-bit 0→15→15→0→0 bounce counter. It adds:
- configurable width;
- runtime lower and upper limits;
- a configurable endpoint dwell;
- selectable wrap-up, wrap-down, bounce and hold modes;
- count enable, synchronous load, and status flags.

It is used as a sequence and address generator for display, scan and PWM-style blocks.

## Interface
Parameters:
- `WIDTH`, default 4. Counter width in bits, ≥2.
- `DWELL`, default 1. Extra enabled cycles the count is held at each endpoint in bounce mode. 0 means no repeat.

Ports:
- `clock`  in  1  rising-edge clock, the single clock domain.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `en`  in  1  count enable. When low, count, dir and dwell state hold.
- `mode`  in  2  0 UP, 1 DOWN, 2 BOUNCE, 3 HOLD.
- `lo`  in  WIDTH  lower limit, unsigned.
- `hi`  in  WIDTH  upper limit, unsigned.
- `load`  in  1  synchronous load of `load_val`. Takes priority over `en`.
- `load_val`  in  WIDTH  load value.
- `count`  out  WIDTH  current count, registered.
- `dir`  out  1  0 = counting up, 1 = counting down, registered.
- `at_lo`  out  1  combinational: `count == lo`.
- `at_hi`  out  1  combinational: `count == hi`.
- `turn`  out  1  registered, one-cycle pulse. High in the cycle after a wrap (UP/DOWN) or a direction reversal (BOUNCE).
- `cfg_err`  out  1  combinational: `lo > hi`.

## Operation
- Reset values:
  - `count` = 0, `dir` = 0, dwell counter = 0, `turn` = 0.
  - `at_lo`/`at_hi`/`cfg_err` follow from `lo`/`hi`.
- Priority per edge: reset > `load` > `cfg_err` > `en` > hold.
- **Load:** `count` ← `load_val` unmodified, even if out of range; dwell ← 0; `dir` unchanged; `turn` = 0. `load` works with `en` = 0.
- **Config error:** while `cfg_err` is set, count/dir/dwell freeze and `turn` = 0.
- **Out of range:** if `count` < `lo` or `count` > `hi` on an enabled edge in UP/DOWN/BOUNCE:
  - `count` ← `lo` if `dir` = 0, else `hi`;
  - dwell ← 0; no `turn`.
- **Single-value range:** `lo == hi` with an in-range count means the count holds and `turn` stays low.
- **UP:** `dir` forced to 0. `count` +1; at `hi` the next value is `lo` and `turn` fires.
- **DOWN:** `dir` forced to 1. `count` −1; at `lo` the next value is `hi` and `turn` fires.
- **BOUNCE:** `dir` retained across mode entry.
  - Away from endpoints: step in `dir`.
  - At the endpoint ahead (`hi` when up, `lo` when down):
    - if dwell < `DWELL`, hold and increment dwell;
    - else toggle `dir`, step once in the new direction, clear dwell, and pulse `turn`.
  - At the trailing endpoint (e.g. `lo` while up): step normally.
- **HOLD:** count, dir and dwell freeze; `turn` = 0.
- **Arithmetic:** WIDTH-bit unsigned; no carry/borrow escapes the range logic.
- **Mode change:** takes effect on the next enabled edge. Dwell is cleared whenever `mode` differs from its value on the previous edge.

## Timing
- Latency: one edge from `en`/`load` to a new `count`. Flags `at_lo`/`at_hi` are valid in the same cycle as `count`.
- `turn` is aligned with the first cycle showing the post-wrap or post-reversal value.
- `reset` assertion clears all registers immediately, mid-dwell or mid-load. The first enabled edge after deassertion gives `count` = 1 (for `lo` = 0).
- `en` low for N cycles stretches the sequence; endpoint dwell counts only enabled edges.

## Structure
- Package `bounce_counter_pkg` holds:
  - `typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_HOLD} cnt_mode_t`;
  - the dwell width function `$clog2(DWELL+1)`, minimum 1.
- Sub-module `bounce_next_state` is combinational. Inputs: count, dir, dwell, mode, lo, hi. Outputs: next count, next dir, next dwell, wrap/turn. The top level holds the registers, load/enable priority and flags.

## Test plan
- **Default bounce.** `WIDTH`=4, `DWELL`=1, `lo`=0, `hi`=15, BOUNCE, `en`=1, 40 cycles. Required sequence: 0,1,…,15,15,14,…,0,0,1. `turn` is high at the first 14 and the first 1 after the 0,0 repeat.
- **Bounce without dwell.** `DWELL`=0, `lo`=3, `hi`=6. Required: 3,4,5,6,5,4,3,4. `dir` toggles with the 5 and with the second 4.
- **UP wrap.** `lo`=2, `hi`=5: 2,3,4,5,2 with `turn` on the 2. **DOWN wrap**, same limits: 5,4,3,2,5 with `turn` on the 5.
- **Load and out of range.** `load`=1 with `load_val`=12 and `hi`=9, both `load` and `en` high, then UP. Required: `count` = 12, then `lo` on the next enabled edge, with no `turn`.
- **Enable and hold.** `en` = 0 for 3 cycles mid-dwell at `hi` (`DWELL`=2): count stays at `hi` for exactly 3 enabled cycles in total. HOLD mode freezes count and `dir`. `lo`=7, `hi`=4 sets `cfg_err`=1 and freezes the count.
- **Async reset.** Assert `reset`=0 between clock edges during the `hi` dwell: `count` = 0, `dir` = 0 and `turn` = 0 immediately. Release: the count resumes 1,2,….

Source files
------------

// File: rtl/bounce_counter_pkg.sv
// Shared types and helpers for the parametrised up/down/bounce counter.
package bounce_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } cnt_mode_t;

  // Width of the dwell counter: enough to hold DWELL, never narrower than 1 bit.
  function automatic int dwell_width(input int dwell);
    int w;
    w = $clog2(dwell + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bounce_next_state.sv
// Combinational next-state logic: given the current count/dir/dwell and the
// limits, computes what the counter becomes on an enabled edge.
module bounce_next_state
  import bounce_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 1,
  parameter int DW    = dwell_width(DWELL)
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_dir,
  input  logic [DW-1:0]    i_dwell,
  input  cnt_mode_t        i_mode,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  output logic [WIDTH-1:0] o_count,
  output logic             o_dir,
  output logic [DW-1:0]    o_dwell,
  output logic             o_turn
);

  logic w_out_of_range;
  logic w_dir_eff;
  logic w_at_ahead;

  assign w_out_of_range = (i_count < i_lo) || (i_count > i_hi);
  assign w_dir_eff      = (i_mode == MODE_UP)   ? 1'b0 :
                          (i_mode == MODE_DOWN) ? 1'b1 : i_dir;
  assign w_at_ahead     = i_dir ? (i_count == i_lo) : (i_count == i_hi);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_count = i_count;
    o_dir   = i_dir;
    o_dwell = i_dwell;
    o_turn  = 1'b0;

    if (i_mode != MODE_HOLD) begin
      o_dir   = w_dir_eff;
      o_dwell = '0;
      if (w_out_of_range) begin
        o_count = w_dir_eff ? i_hi : i_lo;
      end else if (i_lo == i_hi) begin
        o_count = i_count;
      end else begin
        case (i_mode)
          MODE_UP: begin
            if (i_count == i_hi) begin
              o_count = i_lo;
              o_turn  = 1'b1;
            end else begin
              o_count = i_count + WIDTH'(1);
            end
          end
          MODE_DOWN: begin
            if (i_count == i_lo) begin
              o_count = i_hi;
              o_turn  = 1'b1;
            end else begin
              o_count = i_count - WIDTH'(1);
            end
          end
          default: begin
            // Bounce: dwell at the endpoint ahead, then reverse and step away.
            if (w_at_ahead && (i_dwell < DW'(DWELL))) begin
              o_count = i_count;
              o_dwell = i_dwell + DW'(1);
            end else if (w_at_ahead) begin
              o_dir   = ~i_dir;
              o_count = i_dir ? (i_count + WIDTH'(1)) : (i_count - WIDTH'(1));
              o_turn  = 1'b1;
            end else begin
              o_count = i_dir ? (i_count - WIDTH'(1)) : (i_count + WIDTH'(1));
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/bounce_counter_p.sv
// Parametrised wrap/bounce/hold counter with runtime limits, endpoint dwell,
// synchronous load and status flags.
module bounce_counter_p
  import bounce_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             at_lo,
  output logic             at_hi,
  output logic             turn,
  output logic             cfg_err
);

  localparam int DW = dwell_width(DWELL);

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic [DW-1:0]    r_dwell;
  logic             r_turn;
  cnt_mode_t        r_prev_mode;

  cnt_mode_t        w_mode;
  logic             w_cfg_err;
  logic [DW-1:0]    w_dwell_eff;
  logic [WIDTH-1:0] w_nxt_count;
  logic             w_nxt_dir;
  logic [DW-1:0]    w_nxt_dwell;
  logic             w_nxt_turn;

  assign w_mode    = cnt_mode_t'(mode);
  assign w_cfg_err = (lo > hi);
  // A mode change discards any partially accumulated endpoint dwell.
  assign w_dwell_eff = (w_mode != r_prev_mode) ? '0 : r_dwell;

  bounce_next_state #(
    .WIDTH (WIDTH),
    .DWELL (DWELL),
    .DW    (DW)
  ) u_next (
    .i_count (r_count),
    .i_dir   (r_dir),
    .i_dwell (w_dwell_eff),
    .i_mode  (w_mode),
    .i_lo    (lo),
    .i_hi    (hi),
    .o_count (w_nxt_count),
    .o_dir   (w_nxt_dir),
    .o_dwell (w_nxt_dwell),
    .o_turn  (w_nxt_turn)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_dir       <= 1'b0;
      r_dwell     <= '0;
      r_turn      <= 1'b0;
      r_prev_mode <= MODE_UP;
    end else begin
      r_prev_mode <= w_mode;
      r_turn      <= 1'b0;
      if (load) begin
        r_count <= load_val;
        r_dwell <= '0;
      end else if (w_cfg_err || !en) begin
        r_dwell <= w_dwell_eff;
      end else begin
        r_count <= w_nxt_count;
        r_dir   <= w_nxt_dir;
        r_dwell <= w_nxt_dwell;
        r_turn  <= w_nxt_turn;
      end
    end
  end

  assign count   = r_count;
  assign dir     = r_dir;
  assign turn    = r_turn;
  assign at_lo   = (r_count == lo);
  assign at_hi   = (r_count == hi);
  assign cfg_err = w_cfg_err;

endmodule

// File: tb/tb_bounce_counter_p.sv
// Directed bench for bounce_counter_p: three instances (DWELL 1, 0, 2) share
// stimulus; each scenario checks the instance it targets.
module tb_bounce_counter_p;
  import bounce_counter_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] lo, hi, load_val;
  logic       load;

  logic [3:0] count_d1, count_d0, count_d2;
  logic       dir_d1, dir_d0, dir_d2;
  logic       at_lo_d1, at_lo_d0, at_lo_d2;
  logic       at_hi_d1, at_hi_d0, at_hi_d2;
  logic       turn_d1, turn_d0, turn_d2;
  logic       cfg_err_d1, cfg_err_d0, cfg_err_d2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  bounce_counter_p #(.WIDTH(4), .DWELL(1)) u_d1 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .lo(lo), .hi(hi),
    .load(load), .load_val(load_val), .count(count_d1), .dir(dir_d1),
    .at_lo(at_lo_d1), .at_hi(at_hi_d1), .turn(turn_d1), .cfg_err(cfg_err_d1));

  bounce_counter_p #(.WIDTH(4), .DWELL(0)) u_d0 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .lo(lo), .hi(hi),
    .load(load), .load_val(load_val), .count(count_d0), .dir(dir_d0),
    .at_lo(at_lo_d0), .at_hi(at_hi_d0), .turn(turn_d0), .cfg_err(cfg_err_d0));

  bounce_counter_p #(.WIDTH(4), .DWELL(2)) u_d2 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .lo(lo), .hi(hi),
    .load(load), .load_val(load_val), .count(count_d2), .dir(dir_d2),
    .at_lo(at_lo_d2), .at_hi(at_hi_d2), .turn(turn_d2), .cfg_err(cfg_err_d2));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; mode = MODE_BOUNCE; lo = 4'd0; hi = 4'd15;
    load = 1'b0; load_val = 4'd0;
    #12;
    n_checks++;
    if (count_d1 !== 4'd0 || dir_d1 !== 1'b0 || turn_d1 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_regs got count=%0d dir=%0d turn=%0d exp 0 0 0",
               count_d1, dir_d1, turn_d1);
    end
    n_checks++;
    if (at_lo_d1 !== 1'b1 || at_hi_d1 !== 1'b0 || cfg_err_d1 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags got at_lo=%0d at_hi=%0d cfg_err=%0d exp 1 0 0",
               at_lo_d1, at_hi_d1, cfg_err_d1);
    end
    step();
    reset = 1'b1;
    step();
    n_checks++;
    if (count_d1 !== 4'd0) begin
      n_errors++;
      $display("FAIL en_low_hold got %0d exp 0", count_d1);
    end
  endtask

  task automatic test_default_bounce();
    int exp_q[$];
    for (int i = 0; i <= 15; i++) exp_q.push_back(i);
    exp_q.push_back(15);
    for (int i = 14; i >= 0; i--) exp_q.push_back(i);
    exp_q.push_back(0);
    exp_q.push_back(1);
    en = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      logic exp_turn, exp_dir;
      if (k > 0) step();
      exp_turn = (k == 17) || (k == 33);
      exp_dir  = (k >= 17) && (k <= 32);
      n_checks++;
      if (count_d1 !== 4'(exp_q[k]) || turn_d1 !== exp_turn || dir_d1 !== exp_dir) begin
        n_errors++;
        $display("FAIL default_bounce[%0d] got count=%0d turn=%0d dir=%0d exp %0d %0d %0d",
                 k, count_d1, turn_d1, dir_d1, exp_q[k], exp_turn, exp_dir);
      end
    end
    n_checks++;
    if (at_lo_d1 !== 1'b0 || at_hi_d1 !== 1'b0) begin
      n_errors++;
      $display("FAIL default_flags got at_lo=%0d at_hi=%0d exp 0 0", at_lo_d1, at_hi_d1);
    end
  endtask

  task automatic test_bounce_no_dwell();
    int   exp_c [8] = '{3, 4, 5, 6, 5, 4, 3, 4};
    logic exp_d [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    logic exp_t [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    lo = 4'd3; hi = 4'd6; mode = MODE_BOUNCE; en = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (count_d0 !== 4'(exp_c[k]) || dir_d0 !== exp_d[k] || turn_d0 !== exp_t[k]) begin
        n_errors++;
        $display("FAIL no_dwell[%0d] got count=%0d dir=%0d turn=%0d exp %0d %0d %0d",
                 k, count_d0, dir_d0, turn_d0, exp_c[k], exp_d[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_up_wrap();
    int   exp_c [5] = '{2, 3, 4, 5, 2};
    logic exp_t [5] = '{0, 0, 0, 0, 1};
    lo = 4'd2; hi = 4'd5; mode = MODE_UP; en = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (count_d1 !== 4'(exp_c[k]) || turn_d1 !== exp_t[k] || dir_d1 !== 1'b0) begin
        n_errors++;
        $display("FAIL up_wrap[%0d] got count=%0d turn=%0d dir=%0d exp %0d %0d 0",
                 k, count_d1, turn_d1, dir_d1, exp_c[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_down_wrap();
    int   exp_c [4] = '{4, 3, 2, 5};
    logic exp_t [4] = '{0, 0, 0, 1};
    mode = MODE_DOWN; load = 1'b1; load_val = 4'd5;
    step();
    load = 1'b0;
    n_checks++;
    if (count_d1 !== 4'd5 || dir_d1 !== 1'b0 || at_hi_d1 !== 1'b1) begin
      n_errors++;
      $display("FAIL down_load got count=%0d dir=%0d at_hi=%0d exp 5 0 1",
               count_d1, dir_d1, at_hi_d1);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (count_d1 !== 4'(exp_c[k]) || turn_d1 !== exp_t[k] || dir_d1 !== 1'b1) begin
        n_errors++;
        $display("FAIL down_wrap[%0d] got count=%0d turn=%0d dir=%0d exp %0d %0d 1",
                 k, count_d1, turn_d1, dir_d1, exp_c[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_load_oor();
    mode = MODE_UP; lo = 4'd1; hi = 4'd9; en = 1'b1; load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0;
    n_checks++;
    if (count_d1 !== 4'd12 || turn_d1 !== 1'b0) begin
      n_errors++;
      $display("FAIL load_oor got count=%0d turn=%0d exp 12 0", count_d1, turn_d1);
    end
    step();
    n_checks++;
    if (count_d1 !== 4'd1 || turn_d1 !== 1'b0 || at_lo_d1 !== 1'b1) begin
      n_errors++;
      $display("FAIL oor_to_lo got count=%0d turn=%0d at_lo=%0d exp 1 0 1",
               count_d1, turn_d1, at_lo_d1);
    end
    en = 1'b0; load = 1'b1; load_val = 4'd7;
    step();
    load = 1'b0;
    step();
    n_checks++;
    if (count_d1 !== 4'd7) begin
      n_errors++;
      $display("FAIL load_no_en got %0d exp 7", count_d1);
    end
  endtask

  task automatic test_enable_hold();
    int   exp_c [9] = '{1, 2, 3, 3, 3, 3, 3, 3, 2};
    logic exp_e [9] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
    logic exp_t [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    lo = 4'd0; hi = 4'd3; mode = MODE_BOUNCE; en = 1'b1;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      en = exp_e[k];
      step();
      n_checks++;
      if (count_d2 !== 4'(exp_c[k]) || turn_d2 !== exp_t[k]) begin
        n_errors++;
        $display("FAIL dwell_en[%0d] got count=%0d turn=%0d exp %0d %0d",
                 k, count_d2, turn_d2, exp_c[k], exp_t[k]);
      end
    end
    en = 1'b1; mode = MODE_HOLD;
    repeat (3) step();
    n_checks++;
    if (count_d2 !== 4'd2 || dir_d2 !== 1'b1 || turn_d2 !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_mode got count=%0d dir=%0d turn=%0d exp 2 1 0",
               count_d2, dir_d2, turn_d2);
    end
    mode = MODE_BOUNCE;
    step();
    n_checks++;
    if (count_d2 !== 4'd1) begin
      n_errors++;
      $display("FAIL hold_resume got %0d exp 1", count_d2);
    end
    lo = 4'd7; hi = 4'd4;
    #1;
    n_checks++;
    if (cfg_err_d2 !== 1'b1) begin
      n_errors++;
      $display("FAIL cfg_err_flag got %0d exp 1", cfg_err_d2);
    end
    repeat (3) step();
    n_checks++;
    if (count_d2 !== 4'd1 || dir_d2 !== 1'b1 || turn_d2 !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg_err_freeze got count=%0d dir=%0d turn=%0d exp 1 1 0",
               count_d2, dir_d2, turn_d2);
    end
  endtask

  task automatic test_async_reset();
    lo = 4'd0; hi = 4'd15; mode = MODE_BOUNCE; en = 1'b1;
    do_reset();
    repeat (16) step();
    n_checks++;
    if (count_d1 !== 4'd15 || at_hi_d1 !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset_dwell got count=%0d at_hi=%0d exp 15 1", count_d1, at_hi_d1);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (count_d1 !== 4'd0 || dir_d1 !== 1'b0 || turn_d1 !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got count=%0d dir=%0d turn=%0d exp 0 0 0",
               count_d1, dir_d1, turn_d1);
    end
    step();
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (count_d1 !== 4'(k) || dir_d1 !== 1'b0) begin
        n_errors++;
        $display("FAIL resume[%0d] got count=%0d dir=%0d exp %0d 0", k, count_d1, dir_d1, k);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_bounce();
    test_bounce_no_dwell();
    test_up_wrap();
    test_down_wrap();
    test_load_oor();
    test_enable_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
